// File: rtl/pc_sequencer.sv
// Program counter owner and single-outstanding instruction fetch sequencer.
// Issues fetches, holds the returned word for decode, and applies redirects.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_data,
  output logic [31:0] instr_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_addr,
  output logic        misalign_err
);

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StWait,
    StDrain,
    StHold
  } state_e;

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] instr_data_q;
  logic [31:0] instr_pc_q;
  logic        misalign_q;
  logic [31:0] target;

  // Low address bits are dropped; a misaligned target is flagged, not trapped.
  assign target = {redirect_addr[31:2], 2'b00};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      pc_q         <= RESET_PC;
      instr_data_q <= 32'h0;
      instr_pc_q   <= RESET_PC;
      misalign_q   <= 1'b0;
    end else begin
      misalign_q <= redirect_valid && (redirect_addr[1:0] != 2'b00);
      unique case (state_q)
        StIdle: begin
          if (redirect_valid) pc_q <= target;
          state_q <= StReq;
        end
        StReq: begin
          if (redirect_valid) begin
            pc_q    <= target;
            // An accepted request is now stale; its response must be drained.
            state_q <= imem_req_ready ? StDrain : StReq;
          end else if (imem_req_ready) begin
            state_q <= StWait;
          end
        end
        StWait: begin
          if (redirect_valid) begin
            pc_q    <= target;
            state_q <= imem_rsp_valid ? StReq : StDrain;
          end else if (imem_rsp_valid) begin
            instr_data_q <= imem_rsp_data;
            instr_pc_q   <= pc_q;
            state_q      <= StHold;
          end
        end
        StDrain: begin
          if (redirect_valid) pc_q <= target;
          if (imem_rsp_valid) state_q <= StReq;
        end
        StHold: begin
          if (redirect_valid) begin
            pc_q    <= target;
            state_q <= StReq;
          end else if (instr_ready) begin
            pc_q    <= pc_q + 32'd4;
            state_q <= StReq;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign imem_req_valid = (state_q == StReq);
  assign imem_req_addr  = pc_q;
  assign instr_valid    = (state_q == StHold) && !redirect_valid;
  assign instr_data     = instr_data_q;
  assign instr_pc       = instr_pc_q;
  assign misalign_err   = misalign_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: fetch loop, redirects, misalignment, wrap and reset.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_data;
  logic [31:0] instr_pc;
  logic        redirect_valid;
  logic [31:0] redirect_addr;
  logic        misalign_err;

  int n_checks = 0;
  int n_errors = 0;

  pc_sequencer #(.RESET_PC(32'h0000_0100)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr_data     (instr_data),
    .instr_pc       (instr_pc),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .misalign_err   (misalign_err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs are driven from here.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic expect_req(input logic [31:0] addr);
    #1;
    check_eq("req_valid", {31'b0, imem_req_valid}, 32'd1);
    check_eq("req_addr", imem_req_addr, addr);
  endtask

  // Starts in a REQ cycle with ready high; ends in the HOLD cycle of that fetch.
  task automatic fetch(input logic [31:0] addr, input logic [31:0] data);
    expect_req(addr);
    step();
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = data;
    #1;
    check_eq("wait_req_low", {31'b0, imem_req_valid}, 32'd0);
    check_eq("wait_iv_low", {31'b0, instr_valid}, 32'd0);
    step();
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    #1;
    check_eq("hold_iv", {31'b0, instr_valid}, 32'd1);
    check_eq("hold_pc", instr_pc, addr);
    check_eq("hold_data", instr_data, data);
  endtask

  task automatic consume();
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
  endtask

  initial begin
    rst            = 1'b1;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    instr_ready    = 1'b0;
    redirect_valid = 1'b0;
    redirect_addr  = 32'h0;

    // Reset values
    step();
    step();
    #1;
    check_eq("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
    check_eq("rst_req_addr", imem_req_addr, 32'h100);
    check_eq("rst_iv", {31'b0, instr_valid}, 32'd0);
    check_eq("rst_data", instr_data, 32'h0);
    check_eq("rst_pc", instr_pc, 32'h100);
    check_eq("rst_misalign", {31'b0, misalign_err}, 32'd0);

    // Cycle 1 after reset is IDLE, cycle 2 issues the first request
    step();
    rst = 1'b0;
    #1;
    check_eq("idle_req_low", {31'b0, imem_req_valid}, 32'd0);
    step();
    fetch(32'h100, 32'hA000_0100);

    // Held word stays stable while decode stalls
    step();
    #1;
    check_eq("stall_iv", {31'b0, instr_valid}, 32'd1);
    check_eq("stall_pc", instr_pc, 32'h100);
    check_eq("stall_data", instr_data, 32'hA000_0100);
    check_eq("stall_req_low", {31'b0, imem_req_valid}, 32'd0);
    consume();
    fetch(32'h104, 32'hA000_0104);
    consume();
    fetch(32'h108, 32'hA000_0108);

    // Redirect in HOLD beats instr_ready
    redirect_valid = 1'b1;
    redirect_addr  = 32'h200;
    instr_ready    = 1'b1;
    #1;
    check_eq("hold_redir_iv", {31'b0, instr_valid}, 32'd0);
    step();
    redirect_valid = 1'b0;
    instr_ready    = 1'b0;
    fetch(32'h200, 32'hB000_0200);
    consume();

    // Redirect in WAIT without response: drain the late response
    expect_req(32'h204);
    step();
    redirect_valid = 1'b1;
    redirect_addr  = 32'h300;
    step();
    redirect_valid = 1'b0;
    #1;
    check_eq("drain_req_low", {31'b0, imem_req_valid}, 32'd0);
    step();
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hDEAD_BEEF;
    #1;
    check_eq("drain_iv", {31'b0, instr_valid}, 32'd0);
    check_eq("drain_req_low2", {31'b0, imem_req_valid}, 32'd0);
    step();
    imem_rsp_valid = 1'b0;
    #1;
    check_eq("post_drain_iv", {31'b0, instr_valid}, 32'd0);
    fetch(32'h300, 32'hC000_0300);
    consume();

    // Redirect and response together in WAIT: new request next cycle
    expect_req(32'h304);
    step();
    redirect_valid = 1'b1;
    redirect_addr  = 32'h500;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h1234_5678;
    step();
    redirect_valid = 1'b0;
    imem_rsp_valid = 1'b0;
    #1;
    check_eq("wr_iv", {31'b0, instr_valid}, 32'd0);
    fetch(32'h500, 32'hD000_0500);

    // Misaligned redirect target
    redirect_valid = 1'b1;
    redirect_addr  = 32'h402;
    #1;
    check_eq("mis_before", {31'b0, misalign_err}, 32'd0);
    step();
    redirect_valid = 1'b0;
    #1;
    check_eq("mis_pulse", {31'b0, misalign_err}, 32'd1);
    expect_req(32'h400);
    step();
    #1;
    check_eq("mis_cleared", {31'b0, misalign_err}, 32'd0);
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hE000_0400;
    step();
    imem_rsp_valid = 1'b0;
    #1;
    check_eq("mis_hold_pc", instr_pc, 32'h400);

    // PC wrap at the top of the address space
    redirect_valid = 1'b1;
    redirect_addr  = 32'hFFFF_FFFC;
    step();
    redirect_valid = 1'b0;
    fetch(32'hFFFF_FFFC, 32'hF000_FFFC);
    consume();
    expect_req(32'h0000_0000);

    // Reset while in WAIT with late responses
    step();
    rst            = 1'b1;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h5555_AAAA;
    #1;
    check_eq("arst_req_valid", {31'b0, imem_req_valid}, 32'd0);
    check_eq("arst_req_addr", imem_req_addr, 32'h100);
    check_eq("arst_iv", {31'b0, instr_valid}, 32'd0);
    check_eq("arst_data", instr_data, 32'h0);
    check_eq("arst_pc", instr_pc, 32'h100);
    step();
    rst = 1'b0;
    #1;
    check_eq("late_idle_iv", {31'b0, instr_valid}, 32'd0);
    check_eq("late_idle_req", {31'b0, imem_req_valid}, 32'd0);
    step();
    imem_req_ready = 1'b0;
    #1;
    check_eq("late_req_iv", {31'b0, instr_valid}, 32'd0);
    expect_req(32'h100);
    step();
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    #1;
    check_eq("late_req_iv2", {31'b0, instr_valid}, 32'd0);
    fetch(32'h100, 32'h7777_0100);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
